// File: rtl/lsu_issue_queue_pkg.sv
// Shared types and constants for the in-order LSU issue queue.
`ifndef LSU_ISSUE_QUEUE_OPS
`define LSU_ISSUE_QUEUE_OPS
`define LDR_OP 4'h1
`define STR_OP 4'h2
`endif

package lsu_issue_queue_pkg;

    localparam int WORD_SIZE_P       = 32;
    localparam int NUM_PHYS_REG      = 64;
    localparam int ROB_ENTRY         = 32;
    localparam int SB_ENTRY          = 16;
    localparam int WIDTH_OP          = 4;
    localparam int FLAGS_W           = 4;
    localparam int LSQ_DEPTH_DEFAULT = 8;

    localparam int TAG_W = $clog2(NUM_PHYS_REG);
    localparam int ROB_W = $clog2(ROB_ENTRY);
    localparam int SB_W  = $clog2(SB_ENTRY);

    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       dest;
        logic [FLAGS_W-1:0]     flags;
        logic [WORD_SIZE_P-1:0] result;
    } CDB_t;

    typedef struct packed {
        logic                   valid;
        logic [WIDTH_OP-1:0]    opcode;
        logic [WORD_SIZE_P-1:0] op1;
        logic [TAG_W-1:0]       op1_tag;
        logic                   op1_rdy;
        logic [WORD_SIZE_P-1:0] op2;
        logic [TAG_W-1:0]       op2_tag;
        logic                   op2_rdy;
        logic [WORD_SIZE_P-1:0] imm;
        logic [ROB_W-1:0]       rob_dest;
        logic [TAG_W-1:0]       reg_dest;
        logic [SB_W-1:0]        sb_dest;
    } lsq_entry_t;

    typedef struct packed {
        logic [WIDTH_OP-1:0]    opcode;
        logic [WORD_SIZE_P-1:0] op1;
        logic [WORD_SIZE_P-1:0] op2;
        logic [WORD_SIZE_P-1:0] imm;
        logic [ROB_W-1:0]       rob_dest;
        logic [TAG_W-1:0]       reg_dest;
        logic [SB_W-1:0]        sb_dest;
    } lsq_issue_t;

    // Loads only need the base; stores also need their data operand.
    function automatic logic lsq_ready(input lsq_entry_t e);
        return e.valid && e.op1_rdy && (e.op2_rdy || e.opcode != `STR_OP);
    endfunction

endpackage

// File: rtl/lsu_issue_queue_wakeup.sv
// CDB snoop for one queue entry: captures results for pending operand tags.
module lsq_wakeup
    import lsu_issue_queue_pkg::*;
(
    input  lsq_entry_t entry_i,
    input  CDB_t       cdb_i,
    output lsq_entry_t entry_o
);

    logic               hit1;
    logic               hit2;
    logic [FLAGS_W-1:0] unused_flags;

    assign unused_flags = cdb_i.flags;

    always_comb begin
        hit1 = entry_i.valid && cdb_i.valid && !entry_i.op1_rdy
            && (cdb_i.dest == entry_i.op1_tag);
        hit2 = entry_i.valid && cdb_i.valid && !entry_i.op2_rdy
            && (cdb_i.dest == entry_i.op2_tag);
        entry_o = entry_i;
        if (hit1) begin
            entry_o.op1     = cdb_i.result;
            entry_o.op1_rdy = 1'b1;
        end
        if (hit2) begin
            entry_o.op2     = cdb_i.result;
            entry_o.op2_rdy = 1'b1;
        end
    end

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order LDR/STR issue queue feeding fu_lsu; one issue per cycle from head.
module lsu_issue_queue
    import lsu_issue_queue_pkg::*;
#(
    parameter int LSQ_DEPTH = LSQ_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       disp_v_i,
    output logic                       disp_ready_o,
    input  logic [WIDTH_OP-1:0]        disp_opcode_i,
    input  logic [WORD_SIZE_P-1:0]     disp_op1_i,
    input  logic [TAG_W-1:0]           disp_op1_tag_i,
    input  logic                       disp_op1_rdy_i,
    input  logic [WORD_SIZE_P-1:0]     disp_op2_i,
    input  logic [TAG_W-1:0]           disp_op2_tag_i,
    input  logic                       disp_op2_rdy_i,
    input  logic [WORD_SIZE_P-1:0]     disp_imm_i,
    input  logic [ROB_W-1:0]           disp_rob_dest_i,
    input  logic [TAG_W-1:0]           disp_reg_dest_i,
    input  logic [SB_W-1:0]            disp_sb_dest_i,
    input  CDB_t                       cdb_i,
    input  logic                       mispredict_i,
    output logic                       exe_v_o,
    output logic [WIDTH_OP-1:0]        opcode_o,
    output logic [WORD_SIZE_P-1:0]     operand1_o,
    output logic [WORD_SIZE_P-1:0]     operand2_o,
    output logic [WORD_SIZE_P-1:0]     imm_o,
    output logic [ROB_W-1:0]           rob_dest_o,
    output logic [TAG_W-1:0]           reg_dest_o,
    output logic [SB_W-1:0]            sb_dest_o,
    output logic [$clog2(LSQ_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(LSQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lsq_entry_t       entries_q [LSQ_DEPTH];
    lsq_entry_t       entries_d [LSQ_DEPTH];
    lsq_entry_t       woken     [LSQ_DEPTH];
    lsq_entry_t       disp_entry;
    lsq_entry_t       disp_woken;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             exe_v_q;
    logic             exe_v_d;
    lsq_issue_t       iss_q;
    lsq_issue_t       iss_d;
    logic             enq;
    logic             issue;

    assign disp_ready_o = (count_q < CNT_W'(LSQ_DEPTH));

    always_comb begin
        disp_entry          = '0;
        disp_entry.valid    = 1'b1;
        disp_entry.opcode   = disp_opcode_i;
        disp_entry.op1      = disp_op1_i;
        disp_entry.op1_tag  = disp_op1_tag_i;
        disp_entry.op1_rdy  = disp_op1_rdy_i;
        disp_entry.op2      = disp_op2_i;
        disp_entry.op2_tag  = disp_op2_tag_i;
        disp_entry.op2_rdy  = disp_op2_rdy_i;
        disp_entry.imm      = disp_imm_i;
        disp_entry.rob_dest = disp_rob_dest_i;
        disp_entry.reg_dest = disp_reg_dest_i;
        disp_entry.sb_dest  = disp_sb_dest_i;
    end

    for (genvar g = 0; g < LSQ_DEPTH; g++) begin : g_wake
        lsq_wakeup u_wake (
            .entry_i (entries_q[g]),
            .cdb_i   (cdb_i),
            .entry_o (woken[g])
        );
    end

    // The dispatching op snoops the same CDB cycle so it never misses its tag.
    lsq_wakeup u_disp_wake (
        .entry_i (disp_entry),
        .cdb_i   (cdb_i),
        .entry_o (disp_woken)
    );

    always_comb begin
        enq       = disp_v_i && disp_ready_o && !mispredict_i;
        issue     = lsq_ready(entries_q[head_q]) && !mispredict_i;
        entries_d = woken;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (mispredict_i) begin
            for (int i = 0; i < LSQ_DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                entries_d[head_q].valid = 1'b0;
                head_d = head_q + PTR_W'(1);
            end
            if (enq) begin
                entries_d[tail_q] = disp_woken;
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(issue);
        end
    end

    always_comb begin
        exe_v_d = issue;
        iss_d   = iss_q;
        if (issue) begin
            iss_d.opcode   = entries_q[head_q].opcode;
            iss_d.op1      = entries_q[head_q].op1;
            iss_d.op2      = entries_q[head_q].op2;
            iss_d.imm      = entries_q[head_q].imm;
            iss_d.rob_dest = entries_q[head_q].rob_dest;
            iss_d.reg_dest = entries_q[head_q].reg_dest;
            iss_d.sb_dest  = entries_q[head_q].sb_dest;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < LSQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            exe_v_q <= 1'b0;
            iss_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            exe_v_q   <= exe_v_d;
            iss_q     <= iss_d;
        end
    end

    assign exe_v_o    = exe_v_q;
    assign opcode_o   = iss_q.opcode;
    assign operand1_o = iss_q.op1;
    assign operand2_o = iss_q.op2;
    assign imm_o      = iss_q.imm;
    assign rob_dest_o = iss_q.rob_dest;
    assign reg_dest_o = iss_q.reg_dest;
    assign sb_dest_o  = iss_q.sb_dest;
    assign count_o    = count_q;

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Bench for lsu_issue_queue: directed scenarios plus random traffic vs a queue model.
module tb_lsu_issue_queue;
    import lsu_issue_queue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mis;
    logic        d_v, d_r1, d_r2;
    logic [3:0]  d_op;
    logic [31:0] d_o1, d_o2, d_imm;
    logic [5:0]  d_t1, d_t2, d_rd;
    logic [4:0]  d_rob;
    logic [3:0]  d_sb;
    CDB_t        cdb;

    logic        rdy, exe_v;
    logic [3:0]  opc;
    logic [31:0] o1, o2, imm;
    logic [4:0]  rob;
    logic [5:0]  rd;
    logic [3:0]  sb;
    logic [3:0]  cnt;

    lsu_issue_queue dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .disp_v_i        (d_v),
        .disp_ready_o    (rdy),
        .disp_opcode_i   (d_op),
        .disp_op1_i      (d_o1),
        .disp_op1_tag_i  (d_t1),
        .disp_op1_rdy_i  (d_r1),
        .disp_op2_i      (d_o2),
        .disp_op2_tag_i  (d_t2),
        .disp_op2_rdy_i  (d_r2),
        .disp_imm_i      (d_imm),
        .disp_rob_dest_i (d_rob),
        .disp_reg_dest_i (d_rd),
        .disp_sb_dest_i  (d_sb),
        .cdb_i           (cdb),
        .mispredict_i    (mis),
        .exe_v_o         (exe_v),
        .opcode_o        (opc),
        .operand1_o      (o1),
        .operand2_o      (o2),
        .imm_o           (imm),
        .rob_dest_o      (rob),
        .reg_dest_o      (rd),
        .sb_dest_o       (sb),
        .count_o         (cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] v1, v2, imm;
        logic [5:0]  t1, t2, rd;
        bit          r1, r2;
        logic [4:0]  rob;
        logic [3:0]  sb;
    } m_op_t;

    m_op_t       mq[$];
    logic        e_v;
    logic [3:0]  e_op, e_sb;
    logic [31:0] e_o1, e_o2, e_imm;
    logic [4:0]  e_rob;
    logic [5:0]  e_rd;

    function automatic m_op_t wake(input m_op_t o);
        if (cdb.valid && !o.r1 && cdb.dest == o.t1) begin
            o.v1 = cdb.result;
            o.r1 = 1'b1;
        end
        if (cdb.valid && !o.r2 && cdb.dest == o.t2) begin
            o.v2 = cdb.result;
            o.r2 = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step();
        m_op_t n;
        bit    room;
        bit    go;
        if (reset) begin
            mq.delete();
            e_v = 0; e_op = 0; e_o1 = 0; e_o2 = 0;
            e_imm = 0; e_rob = 0; e_rd = 0; e_sb = 0;
            return;
        end
        if (mis) begin
            mq.delete();
            e_v = 0;
            return;
        end
        room = mq.size() < 8;
        go = 0;
        if (mq.size() > 0)
            go = (mq[0].op == `LDR_OP) ? mq[0].r1 : (mq[0].r1 && mq[0].r2);
        e_v = go;
        if (go) begin
            e_op = mq[0].op; e_o1 = mq[0].v1; e_o2 = mq[0].v2;
            e_imm = mq[0].imm; e_rob = mq[0].rob;
            e_rd = mq[0].rd; e_sb = mq[0].sb;
            void'(mq.pop_front());
        end
        foreach (mq[i]) mq[i] = wake(mq[i]);
        if (d_v && room) begin
            n.op = d_op; n.v1 = d_o1; n.t1 = d_t1; n.r1 = d_r1;
            n.v2 = d_o2; n.t2 = d_t2; n.r2 = d_r2; n.imm = d_imm;
            n.rob = d_rob; n.rd = d_rd; n.sb = d_sb;
            mq.push_back(wake(n));
        end
    endtask

    task automatic check_all();
        chk("exe_v", exe_v, e_v);
        chk("count", cnt, mq.size());
        chk("disp_ready", rdy, mq.size() < 8);
        chk("opcode", opc, e_op);
        chk("operand1", o1, e_o1);
        chk("operand2", o2, e_o2);
        chk("imm", imm, e_imm);
        chk("rob_dest", rob, e_rob);
        chk("reg_dest", rd, e_rd);
        chk("sb_dest", sb, e_sb);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        d_v = 0; mis = 0; reset = 0;
        cdb = '0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] v1,
                        input logic [5:0] t1, input logic r1,
                        input logic [31:0] v2, input logic [5:0] t2,
                        input logic r2, input logic [31:0] im,
                        input logic [4:0] rb, input logic [5:0] rg,
                        input logic [3:0] s);
        d_v = 1; d_op = op; d_o1 = v1; d_t1 = t1; d_r1 = r1;
        d_o2 = v2; d_t2 = t2; d_r2 = r2; d_imm = im;
        d_rob = rb; d_rd = rg; d_sb = s;
    endtask

    task automatic bcast(input logic [5:0] tag, input logic [31:0] val);
        cdb.valid  = 1'b1;
        cdb.dest   = tag;
        cdb.flags  = 4'h0;
        cdb.result = val;
    endtask

    function automatic logic [5:0] rtag();
        return ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        disp(`LDR_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        d_v = 0;
        reset = 1;
        cycle();
        chk("rst_count", cnt, 0);
        chk("rst_exe_v", exe_v, 0);
        idle();

        // 1: ready load through an empty queue
        disp(`LDR_OP, 32'h10, 1, 1, 0, 0, 0, 32'h4, 1, 5, 0);
        cycle();
        idle();
        chk("t1_early", exe_v, 0);
        cycle();
        chk("t1_v", exe_v, 1);
        chk("t1_op1", o1, 32'h10);
        chk("t1_imm", imm, 32'h4);
        chk("t1_rd", rd, 5);
        chk("t1_cnt", cnt, 0);

        // 2: store waits for its data via the CDB
        disp(`STR_OP, 32'h100, 1, 1, 0, 7, 0, 32'h8, 2, 0, 3);
        cycle();
        idle();
        cycle();
        cycle();
        bcast(7, 32'hBEEF);
        cycle();
        idle();
        chk("t2_wait", exe_v, 0);
        cycle();
        chk("t2_v", exe_v, 1);
        chk("t2_op2", o2, 32'hBEEF);

        // 3: blocked head holds back a ready younger store
        disp(`LDR_OP, 0, 3, 0, 0, 0, 0, 32'h1, 3, 9, 0);
        cycle();
        disp(`STR_OP, 32'h20, 0, 1, 32'h30, 0, 1, 32'h2, 4, 0, 5);
        cycle();
        idle();
        cycle();
        cycle();
        chk("t3_block", exe_v, 0);
        chk("t3_cnt", cnt, 2);
        bcast(3, 32'h55);
        cycle();
        idle();
        cycle();
        chk("t3_ldr", opc, `LDR_OP);
        chk("t3_ldr_op1", o1, 32'h55);
        cycle();
        chk("t3_str", opc, `STR_OP);
        chk("t3_str_v", exe_v, 1);
        cycle();

        // 4: fill to full, then drain back-to-back across the wrap
        for (int i = 0; i < 8; i++) begin
            disp(`LDR_OP, 0, 9, 0, 0, 0, 0, i, i, 6'(i), 0);
            cycle();
        end
        chk("t4_full_cnt", cnt, 8);
        chk("t4_full_rdy", rdy, 0);
        disp(`LDR_OP, 0, 9, 0, 0, 0, 0, 0, 0, 8, 0);
        cycle();
        idle();
        bcast(9, 32'h99);
        cycle();
        idle();
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t4_order", rd, i);
        end
        cycle();
        chk("t4_drained", exe_v, 0);

        // 5: dispatch and wakeup in the same cycle
        disp(`LDR_OP, 0, 12, 0, 0, 0, 0, 0, 6, 11, 0);
        bcast(12, 32'hCAFE);
        cycle();
        idle();
        cycle();
        chk("t5_v", exe_v, 1);
        chk("t5_op1", o1, 32'hCAFE);

        // 6: mispredict flushes queue and drops the same-cycle dispatch
        for (int i = 0; i < 5; i++) begin
            disp(`LDR_OP, 0, 20, 0, 0, 0, 0, 0, 7, 6'(i), 0);
            cycle();
        end
        disp(`LDR_OP, 32'h1, 0, 1, 0, 0, 0, 0, 8, 30, 0);
        mis = 1;
        cycle();
        idle();
        chk("t6_cnt", cnt, 0);
        chk("t6_v", exe_v, 0);
        bcast(20, 32'h7);
        cycle();
        idle();
        cycle();
        cycle();
        chk("t6_quiet", exe_v, 0);

        // random traffic with occasional flush and reset
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            mis   = ($urandom_range(0, 39) == 0);
            d_v   = ($urandom_range(0, 9) < 6);
            d_op  = ($urandom_range(0, 1) == 0) ? `LDR_OP : `STR_OP;
            d_o1  = $urandom; d_t1 = rtag(); d_r1 = 1'($urandom);
            d_o2  = $urandom; d_t2 = rtag(); d_r2 = 1'($urandom);
            d_imm = $urandom; d_rob = 5'($urandom);
            d_rd  = 6'($urandom); d_sb = 4'($urandom);
            cdb.valid  = 1'($urandom);
            cdb.dest   = rtag();
            cdb.flags  = 4'($urandom);
            cdb.result = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
